// File: rtl/add_pipeline_hs.sv
// Flow-controlled add pipeline: stage k adds k*STEP, with per-stage bubble collapse,
// synchronous flush and an occupancy counter. Define PIPE_SAT_EN for saturating adds.
module add_pipeline_hs #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] d_q     [DEPTH];
  logic [WIDTH-1:0] d_d     [DEPTH];
  logic [WIDTH-1:0] add_res [1:DEPTH-1];
  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] rdy;
  logic [CW-1:0]    count_q, count_d;

`ifdef PIPE_SAT_EN
  logic [DEPTH-1:0] s_q, s_d;
  logic [DEPTH-1:1] add_ovf;
`endif

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + CW'(v[k]);
    end
    return cnt;
  endfunction

  // A stage can move when it is empty or anything downstream can move.
  always_comb begin : ready_chain
    logic acc;
    rdy = '0;
    acc = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc    = acc | ~v_q[k];
      rdy[k] = acc;
    end
  end

  always_comb begin : stage_add
    logic [WIDTH-1:0] inc;
`ifdef PIPE_SAT_EN
    logic [WIDTH:0]   ext;
    add_ovf = '0;
    ext     = '0;
`endif
    add_res = '{default: '0};
    inc     = '0;
    for (int k = 1; k < DEPTH; k++) begin
      inc = WIDTH'(k * STEP);
`ifdef PIPE_SAT_EN
      ext        = {1'b0, d_q[k-1]} + {1'b0, inc};
      add_res[k] = ext[WIDTH] ? {WIDTH{1'b1}} : ext[WIDTH-1:0];
      add_ovf[k] = ext[WIDTH];
`else
      add_res[k] = d_q[k-1] + inc;
`endif
    end
  end

  always_comb begin : next_state
    v_d = v_q;
    d_d = d_q;
`ifdef PIPE_SAT_EN
    s_d = s_q;
`endif
    if (flush) begin
      v_d = '0;
`ifdef PIPE_SAT_EN
      s_d = '0;
`endif
    end else begin
      if (rdy[0]) begin
        v_d[0] = in_valid;
        if (in_valid) begin
          d_d[0] = in_data;
`ifdef PIPE_SAT_EN
          s_d[0] = 1'b0;
`endif
        end
      end
      // Data registers only load on a valid beat; bubbles leave them untouched.
      for (int k = 1; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) begin
            d_d[k] = add_res[k];
`ifdef PIPE_SAT_EN
            s_d[k] = s_q[k-1] | add_ovf[k];
`endif
          end
        end
      end
    end
    count_d = popcount(v_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

`ifdef PIPE_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign out_sat = s_q[DEPTH-1];
`else
  assign out_sat = 1'b0;
`endif

  assign in_ready  = rdy[0] & ~flush;
  assign out_data  = d_q[DEPTH-1];
  assign out_valid = v_q[DEPTH-1];
  assign count     = count_q;

endmodule
